onehot_encoder_pipe: RTL and testbench

//   Parametrised N-to-log2(N) encoder with a registered valid/ready output stage.

---
 rtl/onehot_encoder_pipe.sv | 88 ++++++++
 tb/tb_onehot_encoder_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_pipe.sv
// N-to-log2(N) one-hot/priority encoder with zero/multi-hot flags and a saturating error counter.
// Latency 1; the output register holds while out_valid && !out_ready, in_ready = !out_valid || out_ready.
module onehot_encoder_pipe #(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter bit MSB_FIRST = 1'b0,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             strict,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic             out_zero,
  output logic             out_multi,
  output logic             out_err,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_count
);

  logic         accept;
  logic         nxt_zero;
  logic         nxt_multi;
  logic         nxt_err;
  logic [W-1:0] pri_idx;
  logic [W-1:0] nxt_idx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign nxt_zero  = ~|in_data;
  assign nxt_multi = |(in_data & (in_data - N'(1)));
  assign nxt_err   = nxt_zero || (nxt_multi && strict);

  // The last matching iteration wins, so the scan direction picks the priority.
  always_comb begin
    pri_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (in_data[i]) pri_idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_data[i]) pri_idx = W'(i);
      end
    end
  end

  always_comb begin
    nxt_idx = pri_idx;
    if (nxt_err) nxt_idx = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_idx   <= nxt_idx;
      out_zero  <= nxt_zero;
      out_multi <= nxt_multi;
      out_err   <= nxt_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Counted at acceptance; a coincident clear takes precedence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (accept && nxt_err && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed bench: default, MSB-first and 2-bit-counter instances share one stimulus stream.
module tb_onehot_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       strict;
  logic       out_ready;
  logic       clr_err;

  logic       a_in_ready, a_out_valid, a_out_zero, a_out_multi, a_out_err;
  logic [2:0] a_out_idx;
  logic [7:0] a_err_count;

  logic       m_in_ready, m_out_valid, m_out_zero, m_out_multi, m_out_err;
  logic [2:0] m_out_idx;
  logic [7:0] m_err_count;

  logic       s_in_ready, s_out_valid, s_out_zero, s_out_multi, s_out_err;
  logic [2:0] s_out_idx;
  logic [1:0] s_err_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  onehot_encoder_pipe #(.N(8), .MSB_FIRST(1'b0), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .strict(strict), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idx(a_out_idx), .out_zero(a_out_zero), .out_multi(a_out_multi),
    .out_err(a_out_err), .clr_err(clr_err), .err_count(a_err_count)
  );

  onehot_encoder_pipe #(.N(8), .MSB_FIRST(1'b1), .ERR_W(8)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .strict(strict), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_out_idx), .out_zero(m_out_zero), .out_multi(m_out_multi),
    .out_err(m_out_err), .clr_err(clr_err), .err_count(m_err_count)
  );

  onehot_encoder_pipe #(.N(8), .MSB_FIRST(1'b0), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .strict(strict), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_idx(s_out_idx), .out_zero(s_out_zero), .out_multi(s_out_multi),
    .out_err(s_out_err), .clr_err(clr_err), .err_count(s_err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    strict    = 1'b1;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_idx",   32'(a_out_idx),   32'd0);
    chk("rst_err_count", 32'(a_err_count), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);

    // Strict one-hot sweep, back-to-back
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(1 << k);
      tick();
      chk("sweep_valid", 32'(a_out_valid), 32'd1);
      chk("sweep_idx",   32'(a_out_idx),   32'(k));
      chk("sweep_err",   32'(a_out_err),   32'd0);
      chk("sweep_msb_idx", 32'(m_out_idx), 32'(k));
      chk("sweep_in_ready", 32'(a_in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drain_valid", 32'(a_out_valid), 32'd0);

    // Priority mode
    strict   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'b0101_0100;
    tick();
    chk("pri_lsb_idx",   32'(a_out_idx),   32'd2);
    chk("pri_lsb_multi", 32'(a_out_multi), 32'd1);
    chk("pri_lsb_err",   32'(a_out_err),   32'd0);
    chk("pri_msb_idx",   32'(m_out_idx),   32'd6);
    in_data = 8'hF0;
    tick();
    chk("pri_f0_lsb_idx", 32'(a_out_idx), 32'd4);
    chk("pri_f0_msb_idx", 32'(m_out_idx), 32'd7);
    chk("pri_err_count",  32'(a_err_count), 32'd0);

    // Error words in strict mode
    strict  = 1'b1;
    in_data = 8'h00;
    tick();
    chk("err_zero_flag",  32'(a_out_zero),  32'd1);
    chk("err_zero_err",   32'(a_out_err),   32'd1);
    chk("err_zero_idx",   32'(a_out_idx),   32'd0);
    chk("err_zero_count", 32'(a_err_count), 32'd1);
    in_data = 8'h03;
    tick();
    chk("err_multi_flag", 32'(a_out_multi), 32'd1);
    chk("err_multi_zero", 32'(a_out_zero),  32'd0);
    chk("err_multi_err",  32'(a_out_err),   32'd1);
    chk("err_multi_idx",  32'(a_out_idx),   32'd0);
    chk("err_count_2",    32'(a_err_count), 32'd2);
    in_valid = 1'b0;
    tick();

    // Backpressure: 8'h10 accepted, then stalled for 3 cycles with 8'h20 waiting
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h10;
    tick();
    chk("bp_first_valid", 32'(a_out_valid), 32'd1);
    chk("bp_first_idx",   32'(a_out_idx),   32'd4);
    in_data = 8'h20;
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      chk("bp_hold_valid", 32'(a_out_valid), 32'd1);
      chk("bp_hold_idx",   32'(a_out_idx),   32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("bp_next_valid", 32'(a_out_valid), 32'd1);
    chk("bp_next_idx",   32'(a_out_idx),   32'd5);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", 32'(a_out_valid), 32'd0);
    chk("bp_err_count",   32'(a_err_count), 32'd2);

    // Saturation on the 2-bit counter
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_count",     32'(a_err_count), 32'd0);
    chk("clr_sat_count", 32'(s_err_count), 32'd0);
    in_valid = 1'b1;
    strict   = 1'b1;
    in_data  = 8'h00;
    for (int e = 0; e < 5; e++) tick();
    chk("sat_count",  32'(s_err_count), 32'd3);
    chk("wide_count", 32'(a_err_count), 32'd5);

    // Clear wins over a coincident error acceptance
    clr_err = 1'b1;
    in_data = 8'h81;
    tick();
    clr_err = 1'b0;
    chk("clr_coinc_err",   32'(a_out_err),   32'd1);
    chk("clr_coinc_count", 32'(a_err_count), 32'd0);
    chk("clr_coinc_sat",   32'(s_err_count), 32'd0);

    // Mid-burst reset
    in_data = 8'h01;
    tick();
    chk("burst_valid", 32'(a_out_valid), 32'd1);
    chk("burst_count", 32'(a_err_count), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_idx",   32'(a_out_idx),   32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 32'(a_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
